// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps the phase-accumulator frequency word from f_start to f_stop,
// holding each point dwell+1 cycles, single-shot or continuous, with abort.
module freq_sweep_ctrl #(
    parameter int FW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          mode_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic [DW-1:0] dwell_i,
    output logic [FW-1:0] freq_word_o,
    output logic          acc_en_o,
    output logic          point_strobe_o,
    output logic          busy_o,
    output logic          done_o
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t        state_q;
    logic [FW-1:0] start_q, stop_q, step_q, cur_q, cur_d;
    logic [DW-1:0] dwell_q, cnt_q;
    logic          mode_q, up_q, acc_en_q, strobe_q, busy_q, done_q, last_pt;
    logic [FW:0]   sum, diff;
    // One extra bit catches carry/borrow so the clamp never wraps past f_stop.
    always_comb begin
        sum     = {1'b0, cur_q} + {1'b0, step_q};
        diff    = {1'b0, cur_q} - {1'b0, step_q};
        cur_d   = up_q ? ((sum > {1'b0, stop_q}) ? stop_q : sum[FW-1:0])
                       : ((diff[FW] || diff[FW-1:0] < stop_q) ? stop_q : diff[FW-1:0]);
        last_pt = (cur_q == stop_q) || (step_q == '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            up_q     <= 1'b0;
            cur_q    <= '0;
            cnt_q    <= '0;
            acc_en_q <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    start_q  <= f_start_i;
                    stop_q   <= f_stop_i;
                    step_q   <= f_step_i;
                    dwell_q  <= dwell_i;
                    mode_q   <= mode_i;
                    up_q     <= f_stop_i >= f_start_i;
                    cur_q    <= f_start_i;
                    cnt_q    <= '0;
                    acc_en_q <= 1'b1;
                    busy_q   <= 1'b1;
                    strobe_q <= 1'b1;
                    state_q  <= RUN;
                end
                RUN: if (abort_i) begin
                    cur_q    <= '0;
                    acc_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end else if (cnt_q == dwell_q) begin
                    cnt_q <= '0;
                    if (last_pt && !mode_q) begin
                        cur_q    <= '0;
                        acc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end else begin
                        cur_q    <= last_pt ? start_q : cur_d;
                        strobe_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign freq_word_o    = cur_q;
    assign acc_en_o       = acc_en_q;
    assign point_strobe_o = strobe_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed and randomized sweeps checked cycle by cycle against a point-list model.
module tb_freq_sweep_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, mode_i = 1'b0;
    logic [7:0]  f_start_i = '0, f_stop_i = '0, f_step_i = '0, freq_word_o;
    logic [15:0] dwell_i = '0;
    logic        acc_en_o, point_strobe_o, busy_o, done_o;
    int          checks = 0, errors = 0;

    freq_sweep_ctrl #(.FW(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
        .f_start_i(f_start_i), .f_stop_i(f_stop_i), .f_step_i(f_step_i), .dwell_i(dwell_i),
        .freq_word_o(freq_word_o), .acc_en_o(acc_en_o), .point_strobe_o(point_strobe_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] obs();
        return {freq_word_o, acc_en_o, busy_o, point_strobe_o, done_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected trace is derived from the list of points the sweep should visit.
    // Vector layout: {freq_word, acc_en, busy, point_strobe, done}.
    task automatic run(input int s, input int e, input int st, input int dw, input bit md,
                       input int cut_req, input bit use_rst, input int hz, input string name);
        int            pts[$];
        logic [11:0]   exp_q[$];
        int            p = s;
        int            cut = cut_req;
        int            lim;
        forever begin
            pts.push_back(p);
            if (p == e || st == 0) break;
            if (e >= s) p = (p + st > e) ? e : p + st;
            else        p = (p - st < e) ? e : p - st;
        end
        if (!md && cut >= pts.size() * (dw + 1)) cut = -1;
        if (md && cut < 0) cut = 0;
        do begin
            foreach (pts[k])
                for (int j = 0; j <= dw; j++)
                    exp_q.push_back({8'(pts[k]), 2'b11, j == 0, 1'b0});
        end while (md && exp_q.size() <= cut);
        if (!md) begin
            exp_q.push_back(12'h001);
            exp_q.push_back(12'h000);
        end
        if (cut >= 0) begin
            while (exp_q.size() > cut + 1) void'(exp_q.pop_back());
            exp_q.push_back(12'h000);
            exp_q.push_back(12'h000);
        end
        lim = (cut >= 0) ? cut : exp_q.size() - 1;
        f_start_i = 8'(s);
        f_stop_i  = 8'(e);
        f_step_i  = 8'(st);
        dwell_i   = 16'(dw);
        mode_i    = md;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(obs()), 32'(exp_q[i]));
            if (hz != 0) begin
                f_start_i = 8'($urandom);
                f_stop_i  = 8'($urandom);
                f_step_i  = 8'($urandom);
                dwell_i   = 16'($urandom_range(0, 3));
                mode_i    = 1'($urandom);
            end
            start_i = (i < lim) && (hz == 2 || (hz == 1 && $urandom_range(0, 3) == 0));
            if (i == cut) begin
                if (use_rst) rst_n = 1'b0;
                else abort_i = 1'b1;
            end
            if (i == cut + 1) begin
                rst_n   = 1'b1;
                abort_i = 1'b0;
            end
            tick();
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("reset", 32'(obs()), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle", 32'(obs()), 32'h0);
        run(10, 50, 20, 2, 0, -1, 0, 0, "up_exact");
        run(200, 250, 40, 0, 0, -1, 0, 0, "up_clamp_ovf");
        run(10, 45, 20, 0, 0, -1, 0, 0, "up_nonmult");
        run(50, 10, 15, 1, 0, -1, 0, 0, "down");
        run(10, 50, 0, 3, 0, -1, 0, 0, "step0");
        run(7, 7, 5, 2, 0, -1, 0, 0, "single_pt");
        run(10, 30, 20, 0, 1, 4, 0, 0, "cont_abort");
        f_start_i = 8'd10; f_stop_i = 8'd50; f_step_i = 8'd20; dwell_i = 16'd0;
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        check("start_abort_0", 32'(obs()), 32'h0);
        tick();
        check("start_abort_1", 32'(obs()), 32'h0);
        run(10, 50, 20, 2, 0, -1, 0, 2, "restart_fin");
        run(10, 50, 20, 2, 0, 4, 1, 1, "rst_mid");
        run(250, 5, 100, 1, 0, -1, 0, 1, "down_borrow");
        for (int n = 0; n < 40; n++) begin
            int s  = $urandom_range(0, 255);
            int e  = $urandom_range(0, 255);
            int st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            int dw = $urandom_range(0, 2);
            bit md = 1'($urandom);
            int ct = md ? $urandom_range(0, 40) : (($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1);
            run(s, e, st, dw, md, ct, 1'($urandom), $urandom_range(0, 1), $sformatf("rnd%0d", n));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
